shift_seq: RTL and testbench
============================

# shift_seq

Multi-cycle shift sequencer for the ALU shift path. It accepts one shift request at a time and applies the five power-of-two shift stages (1, 2, 4, 8, 16) one per clock to a single working register. It then posts the result with a one-cycle ready pulse. The CPU issues it from execute in the same way as the multi-cycle mult/div unit, stalling until `data_resultRDY`.

## Interface
Parameters:
- None. The datapath is fixed at 32 bits and the shift amount at 5 bits.

Ports:
- `clock`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `ctrl_start`  in  1  Request strobe, sampled only while idle.
- `ctrl_op`  in  2  Operation select:
  - 00: sll (logical left)
  - 01: sra (arithmetic right)
  - 10: srl (logical right)
  - 11: rol (rotate left)
- `data_operandA`  in  32  Value to shift, latched on accept.
- `ctrl_shiftamt`  in  5  Shift amount, latched on accept.
- `data_result`  out  32  Last completed result; holds between completions.
- `data_resultRDY`  out  1  One-cycle pulse on the cycle the result is valid.
- `busy`  out  1  High while a request is in progress.

## Operation
- **State machine:** IDLE and RUN.
  - IDLE → RUN on a rising edge with `ctrl_start`=1.
  - RUN → IDLE on the edge that applies stage 4.
- **On accept:**
  - Latch `data_operandA` into the working register `w`.
  - Latch `ctrl_shiftamt` into `amt` and `ctrl_op` into `op`.
  - Clear the stage counter `k` (3 bits) to 0.
- **Each RUN edge:**
  - If `amt[k]`=1, update `w` by shifting `2^k` positions according to `op`.
    - sll and srl fill with 0.
    - sra fills with `w[31]`.
    - rol feeds the bits shifted out of the MSB back into the LSB.
  - Otherwise `w` is unchanged.
  - Increment `k`.
- **On the stage-4 edge:**
  - `data_result` ← the final stage value.
  - `data_resultRDY` ← 1 for the next cycle only.
  - State returns to IDLE.
- **Inputs after accept:** `data_operandA`, `ctrl_shiftamt` and `ctrl_op` are don't-care; later changes do not affect the request in flight.
- **Start while busy:** `ctrl_start` during RUN is ignored. It is not queued and causes no error.
- **Zero amount:** `amt`=0 still takes the full 5 cycles and returns the operand unchanged.
- **Intermediate values:** stage values in `w` never appear on `data_result`. `data_result` changes only on completion.
- **`busy` definition:** `busy` = (state == RUN), decoded from the state register.

## Timing
- **Reset:**
  - state = IDLE; `k`, `w`, `amt` and `op` = 0.
  - `data_result` = 0x00000000, `data_resultRDY` = 0, `busy` = 0.
- **Latency:** accept at edge E0. Stages 0–4 are applied at edges E1–E5. `data_resultRDY`=1 and the new `data_result` are visible between E5 and E6. Fixed latency is 5 cycles.
- **`busy`:** high between E0 and E5, exactly 5 cycles.
- **Back-to-back:** `ctrl_start` asserted during the `data_resultRDY` cycle is accepted at E6. Sustained throughput is one result per 6 cycles.
- **Reset mid-operation:** reset at any RUN edge aborts the request.
  - No `data_resultRDY` pulse is produced.
  - `data_result` returns to 0.
  - `ctrl_start` on the same edge as reset is ignored; reset wins.
- **`data_resultRDY`:** a registered output, never combinational from inputs.

## Test plan
- **sll:** sll 0x00000001 by 31, `ctrl_start` at E0 → `busy`=1 for 5 cycles; `data_resultRDY` pulses once after E5 with `data_result`=0x80000000; `busy`=0 in the same cycle.
- **Right shifts:**
  - sra 0x80000000 by 4 → 0xF8000000.
  - srl 0x80000000 by 4 → 0x08000000.
  - sra 0x7FFFFFFF by 31 → 0x00000000.
- **Rotate and zero amount:**
  - rol 0x80000001 by 1 → 0x00000003.
  - rol 0x12345678 by 16 → 0x56781234.
  - sll 0xDEADBEEF by 0 → 0xDEADBEEF, still after 5 cycles.
- **Ignored start and held result:** start sll 0x1 by 1 at E0; at E2, change the operand to 0xFFFFFFFF, the amount to 8, and assert `ctrl_start` again → exactly one `data_resultRDY` at E5 with result 0x00000002; `data_result` holds 0x00000002 for the following 10 idle cycles.
- **Back-to-back:** assert a second request (srl 0x100 by 8) during the `data_resultRDY` cycle → accepted at E6; second pulse after E11 with 0x00000001.
- **Reset mid-operation:** assert reset at E3 of a request → `busy`, `data_resultRDY` and `data_result` are 0 from the next cycle; no ready pulse for the next 10 cycles; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/shift_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_if
//  Description : Request/result bundle for the multi-cycle shift sequencer.
//                The master side issues a request and the slave side (the
//                sequencer) returns the result.
//                  ctrl_start      request strobe, sampled only while idle
//                  ctrl_op         00 sll, 01 sra, 10 srl, 11 rol
//                  data_operandA   32-bit value to shift
//                  ctrl_shiftamt   5-bit shift amount
//                  data_result     last completed result, held between jobs
//                  data_resultRDY  one-cycle pulse when data_result is new
//                  busy            high while a request is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_seq_if;
    logic        ctrl_start;
    logic [1:0]  ctrl_op;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output ctrl_start,
        output ctrl_op,
        output data_operandA,
        output ctrl_shiftamt,
        input  data_result,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_start,
        input  ctrl_op,
        input  data_operandA,
        input  ctrl_shiftamt,
        output data_result,
        output data_resultRDY,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq
//  Description : Multi-cycle 32-bit shift sequencer. A request is latched while
//                idle, then the five power-of-two stages (1, 2, 4, 8, 16) are
//                applied one per clock to a single working register. The
//                final value is posted on data_result together with a
//                one-cycle data_resultRDY pulse. Fixed latency of 5 cycles.
//  Ports       : clock  - rising-edge clock
//                reset  - synchronous, active-high reset
//                bus    - shift_seq_if.slave (request in, result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_seq (
    input  wire logic   clock,
    input  wire logic   reset,
    shift_seq_if.slave  bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [2:0] C_LAST_K = 3'd4;

    localparam logic [1:0] C_OP_SLL = 2'b00;
    localparam logic [1:0] C_OP_SRA = 2'b01;
    localparam logic [1:0] C_OP_SRL = 2'b10;
    localparam logic [1:0] C_OP_ROL = 2'b11;

    logic [0:0]  r_state;
    logic [2:0]  r_k;
    logic [31:0] r_w;
    logic [4:0]  r_amt;
    logic [1:0]  r_op;
    logic [31:0] r_result;
    logic        r_rdy;

    logic [5:0]  w_dist;
    logic [31:0] w_shifted;
    logic [31:0] w_next;

    // Distance for the current stage is 2^k. Six bits so that the rotate
    // complement (32 - dist) is representable.
    assign w_dist = 6'd1 << r_k;

    always_comb begin
        w_shifted = r_w;
        case (r_op)
            C_OP_SLL: w_shifted = r_w << w_dist;
            C_OP_SRA: w_shifted = 32'($signed(r_w) >>> w_dist);
            C_OP_SRL: w_shifted = r_w >> w_dist;
            C_OP_ROL: w_shifted = (r_w << w_dist) | (r_w >> (6'd32 - w_dist));
            default:  w_shifted = r_w;
        endcase
    end

    // A stage is skipped when its amount bit is clear. r_k never exceeds 4
    // while running, so the select stays inside r_amt.
    assign w_next = r_amt[r_k] ? w_shifted : r_w;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_k      <= 3'd0;
            r_w      <= 32'd0;
            r_amt    <= 5'd0;
            r_op     <= 2'd0;
            r_result <= 32'd0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.ctrl_start) begin
                        r_w     <= bus.data_operandA;
                        r_amt   <= bus.ctrl_shiftamt;
                        r_op    <= bus.ctrl_op;
                        r_k     <= 3'd0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // ctrl_start is deliberately not looked at here: a
                    // request arriving mid-run is dropped, not queued.
                    r_w <= w_next;
                    r_k <= r_k + 3'd1;
                    if (r_k == C_LAST_K) begin
                        // Only the final stage value ever reaches the output.
                        r_result <= w_next;
                        r_rdy    <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_seq
//  Description : Self-checking bench for shift_seq. Expected results are
//                queued when a request is driven and compared when the
//                sequencer pulses data_resultRDY.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq;

    logic clk;
    logic rst;

    shift_seq_if bus ();

    shift_seq u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] sb_q[$];

    // Reference model written directly in terms of the full shift amount.
    function automatic logic [31:0] ref_shift(logic [1:0] op, logic [31:0] a, logic [4:0] amt);
        logic [5:0] s;
        s = {1'b0, amt};
        case (op)
            OP_SLL:  return a << s;
            OP_SRA:  return 32'($signed(a) >>> s);
            OP_SRL:  return a >> s;
            default: return (amt == 5'd0) ? a : ((a << s) | (a >> (6'd32 - s)));
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic fail_now(string name);
        n_total++;
        $display("FAIL %s: got nothing, expected a result", name);
    endtask

    // Called at a negedge; the request is sampled at the next rising edge.
    // Returns at the negedge after acceptance with the inputs scrambled.
    task automatic launch(logic [1:0] op, logic [31:0] a, logic [4:0] amt, logic [31:0] exp);
        bus.ctrl_start    = 1'b1;
        bus.ctrl_op       = op;
        bus.data_operandA = a;
        bus.ctrl_shiftamt = amt;
        sb_q.push_back(exp);
        @(negedge clk);
        bus.ctrl_start    = 1'b0;
        bus.ctrl_op       = 2'($urandom);
        bus.data_operandA = $urandom;
        bus.ctrl_shiftamt = 5'($urandom);
    endtask

    // Waits (bounded) for the ready pulse, checking busy throughout, the
    // number of cycles waited and the result against the scoreboard.
    task automatic await_result(string name, int exp_wait);
        int          n       = 0;
        logic        busy_ok = 1'b1;
        logic [31:0] exp;
        while (!bus.data_resultRDY && n < 20) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({name, " wait"}, 32'(n), 32'(exp_wait));
        check({name, " busy-run"}, 32'(busy_ok), 32'd1);
        check({name, " busy-at-rdy"}, 32'(bus.busy), 32'd0);
        if (sb_q.size() == 0) fail_now({name, " scoreboard"});
        else begin
            exp = sb_q.pop_front();
            check(name, bus.data_result, exp);
        end
    endtask

    task automatic after_pulse(string name);
        @(negedge clk);
        check({name, " rdy-single"}, 32'(bus.data_resultRDY), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1] = '{OP_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[2] = '{OP_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[3] = '{OP_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
        vecs[4] = '{OP_ROL, 32'h8000_0001, 5'd1,  32'h0000_0003};
        vecs[5] = '{OP_ROL, 32'h1234_5678, 5'd16, 32'h5678_1234};
        vecs[6] = '{OP_SLL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};

        rst               = 1'b1;
        bus.ctrl_start    = 1'b0;
        bus.ctrl_op       = 2'd0;
        bus.data_operandA = 32'd0;
        bus.ctrl_shiftamt = 5'd0;
        repeat (3) @(negedge clk);
        check("reset result", bus.data_result, 32'd0);
        check("reset rdy", 32'(bus.data_resultRDY), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].amt, vecs[i].exp);
            await_result($sformatf("vec%0d", i), 5);
            after_pulse($sformatf("vec%0d", i));
        end

        // Random vectors against the reference model.
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [4:0]  amt;
            op  = 2'($urandom);
            a   = $urandom;
            amt = 5'($urandom);
            launch(op, a, amt, ref_shift(op, a, amt));
            await_result($sformatf("rnd%0d", i), 5);
            after_pulse($sformatf("rnd%0d", i));
        end

        // Start during RUN with changed inputs is ignored; result then holds.
        launch(OP_SLL, 32'h1, 5'd1, 32'h2);
        @(negedge clk);
        bus.ctrl_op       = OP_SLL;
        bus.data_operandA = 32'hFFFF_FFFF;
        bus.ctrl_shiftamt = 5'd8;
        bus.ctrl_start    = 1'b1;
        @(negedge clk);
        bus.ctrl_start = 1'b0;
        await_result("ignored-start", 3);
        begin
            int bad = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.data_resultRDY !== 1'b0 || bus.data_result !== 32'h2 || bus.busy !== 1'b0) bad++;
            end
            check("hold bad-cycles", 32'(bad), 32'd0);
        end

        // Back-to-back: second request driven during the ready cycle.
        launch(OP_SLL, 32'h0000_00F0, 5'd3, 32'h0000_0780);
        await_result("b2b first", 5);
        launch(OP_SRL, 32'h0000_0100, 5'd8, 32'h0000_0001);
        check("b2b rdy-single", 32'(bus.data_resultRDY), 32'd0);
        check("b2b accepted", 32'(bus.busy), 32'd1);
        await_result("b2b second", 5);
        after_pulse("b2b second");

        // Reset mid-operation at E3, with a start on the same edge.
        launch(OP_SLL, 32'h1, 5'd4, 32'h10);
        @(negedge clk);
        @(negedge clk);
        rst            = 1'b1;
        bus.ctrl_start = 1'b1;
        @(negedge clk);
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst rdy", 32'(bus.data_resultRDY), 32'd0);
        check("midrst result", bus.data_result, 32'd0);
        rst            = 1'b0;
        bus.ctrl_start = 1'b0;
        void'(sb_q.pop_back());
        begin
            int pulses = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.data_resultRDY) pulses++;
            end
            check("midrst pulses", 32'(pulses), 32'd0);
        end
        launch(OP_ROL, 32'hF000_000F, 5'd4, 32'h0000_00FF);
        await_result("post-rst", 5);
        after_pulse("post-rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
